// File: rtl/flash_port_arbiter_pkg.sv
// Shared definitions for the two-client flash_ctrl port arbiter: operation
// codes, FSM encoding, page limit and the request legality check.
package flash_port_arbiter_pkg;

    localparam logic [1:0] OP_CLEAR = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    localparam int MAX_NUM = 256;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_ERR       = 2'd3
    } state_t;

    // Clear ignores num except for the page limit; write/read need at least one byte.
    function automatic logic op_illegal(input logic [1:0] op_type,
                                        input logic [8:0] op_num,
                                        input int         max_num);
        return (op_type == 2'd3) ||
               (((op_type == OP_WRITE) || (op_type == OP_READ)) && (op_num == 9'd0)) ||
               (int'({23'd0, op_num}) > max_num);
    endfunction

endpackage

// File: rtl/flash_port_arbiter_rr_arb2.sv
// Two-way round-robin winner select. The pointer names the favoured port; with
// no request pending the favoured port is reported as winner.
module flash_port_arbiter_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic       winner
);

    always_comb begin
        winner = prio;
        if (!valid[prio] && valid[~prio])
            winner = ~prio;
    end

endmodule

// File: rtl/flash_port_arbiter.sv
// Round-robin arbiter sharing one flash_ctrl user interface between two clients.
// A grant is held from request handshake until the operation (and read drain) completes.
module flash_port_arbiter
    import flash_port_arbiter_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_MAX_NUM    = MAX_NUM
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic [1:0]              i_p0_operation_type,
    input  logic [23:0]             i_p0_operation_addr,
    input  logic [8:0]              i_p0_operation_num,
    input  logic                    i_p0_operation_valid,
    output logic                    o_p0_operation_ready,
    output logic                    o_p0_error,
    input  logic [P_DATA_WIDTH-1:0] i_p0_write_data,
    input  logic                    i_p0_write_sop,
    input  logic                    i_p0_write_eop,
    input  logic                    i_p0_write_valid,
    output logic [P_DATA_WIDTH-1:0] o_p0_read_data,
    output logic                    o_p0_read_sop,
    output logic                    o_p0_read_eop,
    output logic                    o_p0_read_valid,

    input  logic [1:0]              i_p1_operation_type,
    input  logic [23:0]             i_p1_operation_addr,
    input  logic [8:0]              i_p1_operation_num,
    input  logic                    i_p1_operation_valid,
    output logic                    o_p1_operation_ready,
    output logic                    o_p1_error,
    input  logic [P_DATA_WIDTH-1:0] i_p1_write_data,
    input  logic                    i_p1_write_sop,
    input  logic                    i_p1_write_eop,
    input  logic                    i_p1_write_valid,
    output logic [P_DATA_WIDTH-1:0] o_p1_read_data,
    output logic                    o_p1_read_sop,
    output logic                    o_p1_read_eop,
    output logic                    o_p1_read_valid,

    output logic [1:0]              o_ctrl_operation_type,
    output logic [23:0]             o_ctrl_operation_addr,
    output logic [8:0]              o_ctrl_operation_num,
    output logic                    o_ctrl_operation_valid,
    input  logic                    i_ctrl_operation_ready,
    output logic [P_DATA_WIDTH-1:0] o_ctrl_write_data,
    output logic                    o_ctrl_write_sop,
    output logic                    o_ctrl_write_eop,
    output logic                    o_ctrl_write_valid,
    input  logic [P_DATA_WIDTH-1:0] i_ctrl_read_data,
    input  logic                    i_ctrl_read_sop,
    input  logic                    i_ctrl_read_eop,
    input  logic                    i_ctrl_read_valid
);

    state_t      r_state, s_next;
    logic        r_prio, r_grant, r_eop_seen;
    logic [1:0]  r_type;
    logic [23:0] r_addr;
    logic [8:0]  r_num;

    logic        s_win, s_hs, s_illegal, s_busy, s_done, s_rd_route;
    logic [1:0]  s_type;
    logic [23:0] s_addr;
    logic [8:0]  s_num;

    flash_port_arbiter_rr_arb2 u_arb (
        .valid  ({i_p1_operation_valid, i_p0_operation_valid}),
        .prio   (r_prio),
        .winner (s_win)
    );

    assign s_type    = s_win ? i_p1_operation_type : i_p0_operation_type;
    assign s_addr    = s_win ? i_p1_operation_addr : i_p0_operation_addr;
    assign s_num     = s_win ? i_p1_operation_num  : i_p0_operation_num;
    assign s_illegal = op_illegal(s_type, s_num, P_MAX_NUM);

    // Ready is also masked by reset so every output reads 0 while i_rst is high.
    assign o_p0_operation_ready = (r_state == ST_IDLE) && !i_rst && i_ctrl_operation_ready && !s_win;
    assign o_p1_operation_ready = (r_state == ST_IDLE) && !i_rst && i_ctrl_operation_ready &&  s_win;
    assign s_hs = s_win ? (o_p1_operation_ready && i_p1_operation_valid)
                        : (o_p0_operation_ready && i_p0_operation_valid);

    assign s_busy     = (r_state == ST_ISSUE) || (r_state == ST_WAIT_DONE);
    assign s_rd_route = s_busy && (r_type == OP_READ);
    assign s_done     = (r_state == ST_WAIT_DONE) && i_ctrl_operation_ready &&
                        ((r_type != OP_READ) || r_eop_seen);

    always_comb begin
        s_next = r_state;
        case (r_state)
            ST_IDLE:      if (s_hs) s_next = s_illegal ? ST_ERR : ST_ISSUE;
            ST_ISSUE:     if (i_ctrl_operation_ready) s_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (s_done) s_next = ST_IDLE;
            ST_ERR:       s_next = ST_IDLE;
            default:      s_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= s_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio     <= 1'b0;
            r_grant    <= 1'b0;
            r_eop_seen <= 1'b0;
            r_type     <= '0;
            r_addr     <= '0;
            r_num      <= '0;
        end else begin
            if (s_hs) begin
                r_grant <= s_win;
                r_type  <= s_type;
                r_addr  <= s_addr;
                r_num   <= s_num;
            end
            if (s_hs && !s_illegal)
                r_eop_seen <= 1'b0;
            else if (s_rd_route && i_ctrl_read_valid && i_ctrl_read_eop)
                r_eop_seen <= 1'b1;
            if (s_done || (r_state == ST_ERR))
                r_prio <= ~r_grant;
        end
    end

    assign o_ctrl_operation_valid = (r_state == ST_ISSUE);
    assign o_ctrl_operation_type  = (r_state == ST_ISSUE) ? r_type : '0;
    assign o_ctrl_operation_addr  = (r_state == ST_ISSUE) ? r_addr : '0;
    assign o_ctrl_operation_num   = (r_state == ST_ISSUE) ? r_num  : '0;

    assign o_p0_error = (r_state == ST_ERR) && !r_grant;
    assign o_p1_error = (r_state == ST_ERR) &&  r_grant;

    // The non-granted client's write stream is simply dropped.
    assign o_ctrl_write_data  = !s_busy ? '0   : (r_grant ? i_p1_write_data  : i_p0_write_data);
    assign o_ctrl_write_sop   = !s_busy ? 1'b0 : (r_grant ? i_p1_write_sop   : i_p0_write_sop);
    assign o_ctrl_write_eop   = !s_busy ? 1'b0 : (r_grant ? i_p1_write_eop   : i_p0_write_eop);
    assign o_ctrl_write_valid = !s_busy ? 1'b0 : (r_grant ? i_p1_write_valid : i_p0_write_valid);

    assign o_p0_read_data  = (s_rd_route && !r_grant) ? i_ctrl_read_data  : '0;
    assign o_p0_read_sop   = (s_rd_route && !r_grant) && i_ctrl_read_sop;
    assign o_p0_read_eop   = (s_rd_route && !r_grant) && i_ctrl_read_eop;
    assign o_p0_read_valid = (s_rd_route && !r_grant) && i_ctrl_read_valid;
    assign o_p1_read_data  = (s_rd_route &&  r_grant) ? i_ctrl_read_data  : '0;
    assign o_p1_read_sop   = (s_rd_route &&  r_grant) && i_ctrl_read_sop;
    assign o_p1_read_eop   = (s_rd_route &&  r_grant) && i_ctrl_read_eop;
    assign o_p1_read_valid = (s_rd_route &&  r_grant) && i_ctrl_read_valid;

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Directed bench for flash_port_arbiter: write, arbitration order, read drain,
// illegal requests, controller back-pressure and mid-operation reset.
module tb_flash_port_arbiter;

    logic        i_clk, i_rst;
    logic [1:0]  p0_type, p1_type;
    logic [23:0] p0_addr, p1_addr;
    logic [8:0]  p0_num, p1_num;
    logic        p0_valid, p1_valid;
    logic        o_p0_operation_ready, o_p1_operation_ready, o_p0_error, o_p1_error;
    logic [7:0]  p0_wdata, p1_wdata;
    logic        p0_wsop, p0_weop, p0_wvalid, p1_wsop, p1_weop, p1_wvalid;
    logic [7:0]  o_p0_read_data, o_p1_read_data;
    logic        o_p0_read_sop, o_p0_read_eop, o_p0_read_valid;
    logic        o_p1_read_sop, o_p1_read_eop, o_p1_read_valid;
    logic [1:0]  o_ctrl_operation_type;
    logic [23:0] o_ctrl_operation_addr;
    logic [8:0]  o_ctrl_operation_num;
    logic        o_ctrl_operation_valid, ctrl_rdy;
    logic [7:0]  o_ctrl_write_data, c_rdata;
    logic        o_ctrl_write_sop, o_ctrl_write_eop, o_ctrl_write_valid;
    logic        c_rsop, c_reop, c_rvalid;

    int n_chk  = 0;
    int n_pass = 0;

    flash_port_arbiter #(.P_DATA_WIDTH(8), .P_MAX_NUM(256)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_p0_operation_type(p0_type), .i_p0_operation_addr(p0_addr),
        .i_p0_operation_num(p0_num), .i_p0_operation_valid(p0_valid),
        .o_p0_operation_ready(o_p0_operation_ready), .o_p0_error(o_p0_error),
        .i_p0_write_data(p0_wdata), .i_p0_write_sop(p0_wsop),
        .i_p0_write_eop(p0_weop), .i_p0_write_valid(p0_wvalid),
        .o_p0_read_data(o_p0_read_data), .o_p0_read_sop(o_p0_read_sop),
        .o_p0_read_eop(o_p0_read_eop), .o_p0_read_valid(o_p0_read_valid),
        .i_p1_operation_type(p1_type), .i_p1_operation_addr(p1_addr),
        .i_p1_operation_num(p1_num), .i_p1_operation_valid(p1_valid),
        .o_p1_operation_ready(o_p1_operation_ready), .o_p1_error(o_p1_error),
        .i_p1_write_data(p1_wdata), .i_p1_write_sop(p1_wsop),
        .i_p1_write_eop(p1_weop), .i_p1_write_valid(p1_wvalid),
        .o_p1_read_data(o_p1_read_data), .o_p1_read_sop(o_p1_read_sop),
        .o_p1_read_eop(o_p1_read_eop), .o_p1_read_valid(o_p1_read_valid),
        .o_ctrl_operation_type(o_ctrl_operation_type),
        .o_ctrl_operation_addr(o_ctrl_operation_addr),
        .o_ctrl_operation_num(o_ctrl_operation_num),
        .o_ctrl_operation_valid(o_ctrl_operation_valid),
        .i_ctrl_operation_ready(ctrl_rdy),
        .o_ctrl_write_data(o_ctrl_write_data), .o_ctrl_write_sop(o_ctrl_write_sop),
        .o_ctrl_write_eop(o_ctrl_write_eop), .o_ctrl_write_valid(o_ctrl_write_valid),
        .i_ctrl_read_data(c_rdata), .i_ctrl_read_sop(c_rsop),
        .i_ctrl_read_eop(c_reop), .i_ctrl_read_valid(c_rvalid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    // Asynchronous reset; outputs are checked while reset is still asserted.
    task automatic do_reset();
        i_rst    = 1'b1;
        ctrl_rdy = 1'b0;
        #1;
        chk("rst_ctrl_valid", o_ctrl_operation_valid, 0);
        chk("rst_ctrl_addr",  o_ctrl_operation_addr, 0);
        chk("rst_p0_ready",   o_p0_operation_ready, 0);
        chk("rst_p1_ready",   o_p1_operation_ready, 0);
        chk("rst_wr_valid",   o_ctrl_write_valid, 0);
        chk("rst_wr_data",    o_ctrl_write_data, 0);
        chk("rst_p0_err",     o_p0_error, 0);
        chk("rst_p1_rvalid",  o_p1_read_valid, 0);
        repeat (2) tick();
        i_rst = 1'b0;
    endtask

    logic [1:0] vt[5];
    logic [8:0] vn[5];
    logic       ve[5];

    initial begin
        vt = '{2'd1, 2'd1, 2'd3, 2'd0, 2'd1};
        vn = '{9'd0, 9'd300, 9'd4, 9'd0, 9'd256};
        ve = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        p0_type = '0; p0_addr = '0; p0_num = '0; p0_valid = 0;
        p1_type = '0; p1_addr = '0; p1_num = '0; p1_valid = 0;
        p0_wdata = '0; p0_wsop = 0; p0_weop = 0; p0_wvalid = 0;
        p1_wdata = '0; p1_wsop = 0; p1_weop = 0; p1_wvalid = 0;
        c_rdata = '0; c_rsop = 0; c_reop = 0; c_rvalid = 0;
        ctrl_rdy = 0; i_rst = 0;
        do_reset();

        // P0 write of 4 bytes; P1 streams junk that must be dropped
        ctrl_rdy = 1; p0_valid = 1; p0_type = 2'd1; p0_addr = 24'h000100; p0_num = 9'd4;
        #1;
        chk("t1_p0_ready", o_p0_operation_ready, 1);
        chk("t1_p1_ready", o_p1_operation_ready, 0);
        tick();
        p0_valid = 0;
        #1;
        chk("t1_ctrl_valid", o_ctrl_operation_valid, 1);
        chk("t1_ctrl_type",  o_ctrl_operation_type, 1);
        chk("t1_ctrl_addr",  o_ctrl_operation_addr, 32'h100);
        chk("t1_ctrl_num",   o_ctrl_operation_num, 4);
        tick();
        ctrl_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            p0_wdata = 8'(8'hA0 + i); p0_wsop = (i == 0); p0_weop = (i == 3); p0_wvalid = 1;
            p1_wdata = 8'h55; p1_wsop = 1; p1_weop = 1; p1_wvalid = 1;
            #1;
            chk("t1_wr_data",  o_ctrl_write_data, 32'hA0 + i);
            chk("t1_wr_valid", o_ctrl_write_valid, 1);
            chk("t1_wr_sop",   o_ctrl_write_sop, (i == 0));
            chk("t1_wr_eop",   o_ctrl_write_eop, (i == 3));
            chk("t1_p1_quiet", {o_p1_read_valid, o_p1_error, o_p1_operation_ready}, 0);
            tick();
        end
        p0_wvalid = 0; p0_wsop = 0; p0_weop = 0;
        p1_wvalid = 0; p1_wsop = 0; p1_weop = 0;
        ctrl_rdy = 1;
        #1;
        chk("t1_wr_idle",    o_ctrl_write_valid, 0);
        chk("t1_hold_grant", o_p0_operation_ready, 0);
        tick();

        // Both valid from reset: P0, then P1, then queued P0
        do_reset();
        ctrl_rdy = 1;
        p0_valid = 1; p0_type = 2'd0; p0_addr = 24'h10; p0_num = 9'd1;
        p1_valid = 1; p1_type = 2'd0; p1_addr = 24'h20; p1_num = 9'd1;
        #1;
        chk("t2_p0_first",  o_p0_operation_ready, 1);
        chk("t2_p1_wait",   o_p1_operation_ready, 0);
        tick();
        p0_valid = 0;
        #1;
        chk("t2_ctrl_addr0", o_ctrl_operation_addr, 32'h10);
        chk("t2_p1_busy",    o_p1_operation_ready, 0);
        tick();
        ctrl_rdy = 0;
        #1;
        chk("t2_wait_cv",    o_ctrl_operation_valid, 0);
        tick();
        ctrl_rdy = 1;
        #1;
        chk("t2_wait_p1",    o_p1_operation_ready, 0);
        tick();
        p0_valid = 1; p0_addr = 24'h30;
        #1;
        chk("t2_p1_next",    o_p1_operation_ready, 1);
        chk("t2_p0_behind",  o_p0_operation_ready, 0);
        tick();
        p1_valid = 0;
        #1;
        chk("t2_ctrl_addr1", o_ctrl_operation_addr, 32'h20);
        tick();
        #1;
        chk("t2_p0_held",    o_p0_operation_ready, 0);
        tick();
        #1;
        chk("t2_p0_third",   o_p0_operation_ready, 1);
        tick();
        p0_valid = 0;
        #1;
        chk("t2_ctrl_addr2", o_ctrl_operation_addr, 32'h30);
        tick();
        tick();

        // P1 read of 16 bytes; controller ready returns before eop
        p1_valid = 1; p1_type = 2'd2; p1_addr = 24'h200; p1_num = 9'd16;
        #1;
        chk("t3_p1_ready", o_p1_operation_ready, 1);
        tick();
        p1_valid = 0;
        #1;
        chk("t3_ctrl_type", o_ctrl_operation_type, 2);
        chk("t3_ctrl_num",  o_ctrl_operation_num, 16);
        tick();
        for (int i = 0; i < 16; i++) begin
            c_rdata = 8'(8'h40 + i); c_rsop = (i == 0); c_reop = (i == 15); c_rvalid = 1;
            #1;
            chk("t3_p1_data",  o_p1_read_data, 32'h40 + i);
            chk("t3_p1_flags", {o_p1_read_valid, o_p1_read_sop, o_p1_read_eop},
                               {1'b1, (i == 0), (i == 15)});
            chk("t3_p0_quiet", {o_p0_read_valid, o_p0_operation_ready}, 0);
            tick();
        end
        c_rvalid = 0; c_rsop = 0; c_reop = 0;
        #1;
        chk("t3_drained", o_p1_read_valid, 0);
        tick();

        // Illegal and boundary-legal requests from P0
        for (int k = 0; k < 5; k++) begin
            p0_valid = 1; p0_type = vt[k]; p0_addr = 24'h400; p0_num = vn[k];
            #1;
            chk("t4_p0_ready", o_p0_operation_ready, 1);
            tick();
            p0_valid = 0;
            #1;
            chk("t4_err",        o_p0_error, ve[k]);
            chk("t4_ctrl_valid", o_ctrl_operation_valid, !ve[k]);
            chk("t4_p1_err",     o_p1_error, 0);
            tick();
            #1;
            chk("t4_err_clear",  o_p0_error, 0);
            if (!ve[k]) tick();
            else chk("t4_no_issue", o_ctrl_operation_valid, 0);
        end

        // Controller stalled: no client gets ready
        ctrl_rdy = 0; p0_valid = 1; p1_valid = 1;
        p0_type = 2'd1; p0_num = 9'd1; p1_type = 2'd1; p1_num = 9'd1;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk("t5_p0_ready", o_p0_operation_ready, 0);
            chk("t5_p1_ready", o_p1_operation_ready, 0);
            tick();
        end
        p0_valid = 0; p1_valid = 0;
        tick();
        #1;
        chk("t5_no_latch", o_ctrl_operation_valid, 0);

        // Reset during WAIT_DONE of a P0 write; priority returns to P0
        ctrl_rdy = 1; p0_valid = 1; p0_type = 2'd1; p0_addr = 24'h300; p0_num = 9'd2;
        #1;
        chk("t6_p0_ready", o_p0_operation_ready, 1);
        tick();
        p0_valid = 0;
        tick();
        ctrl_rdy = 0;
        p0_wdata = 8'h77; p0_wsop = 1; p0_wvalid = 1;
        #1;
        chk("t6_wr_active", o_ctrl_write_valid, 1);
        do_reset();
        p0_wvalid = 0; p0_wsop = 0;
        ctrl_rdy = 1; p0_valid = 1; p1_valid = 1;
        #1;
        chk("t6_p0_prio", o_p0_operation_ready, 1);
        chk("t6_p1_wait", o_p1_operation_ready, 0);
        p0_valid = 0; p1_valid = 0; ctrl_rdy = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
